// File: rtl/mem_arbiter.sv
// Two-port round-robin front end for a single-port banked memory.
// One transaction in flight at a time; read data returns RD_LAT edges after the command.
module mem_arbiter #(
  parameter int AW     = 12,
  parameter int DW     = 8,
  parameter int RD_LAT = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0,
  input  logic          req1,
  input  logic          we0,
  input  logic          we1,
  input  logic [AW-1:0] addr0,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata0,
  input  logic [DW-1:0] wdata1,
  output logic          gnt0,
  output logic          gnt1,
  output logic          rvalid0,
  output logic          rvalid1,
  output logic [DW-1:0] rdata,
  output logic          busy,
  output logic          mem_cen,
  output logic          mem_rd,
  output logic          mem_wr,
  output logic [AW-1:0] mem_add,
  output logic [DW-1:0] mem_din,
  input  logic [DW-1:0] mem_dout
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;
  typedef struct packed {
    logic          port;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } txn_t;

  localparam logic [2:0] LAT = 3'(RD_LAT);

  state_t        state, state_nxt;
  txn_t          cur, cur_nxt, pick;
  logic          ptr, ptr_nxt, win, done, arb;
  logic [2:0]    cnt, cnt_nxt;
  logic [1:0]    gnt_q, gnt_nxt, rvalid_q, rvalid_nxt;
  logic [DW-1:0] rdata_nxt, din_nxt;
  logic [AW-1:0] add_nxt;
  logic          cen_nxt, rd_nxt, wr_nxt, busy_nxt;

  assign gnt0    = gnt_q[0];
  assign gnt1    = gnt_q[1];
  assign rvalid0 = rvalid_q[0];
  assign rvalid1 = rvalid_q[1];

  always_comb begin
    state_nxt  = state;
    cur_nxt    = cur;
    ptr_nxt    = ptr;
    cnt_nxt    = cnt;
    gnt_nxt    = '0;
    rvalid_nxt = '0;
    rdata_nxt  = rdata;
    cen_nxt    = 1'b1;
    rd_nxt     = 1'b0;
    wr_nxt     = 1'b0;
    add_nxt    = mem_add;
    din_nxt    = mem_din;
    done       = (state == WAIT) && (cnt == LAT);
    // the read-capture edge doubles as an IDLE sampling edge, so rvalid and the next gnt may coincide
    arb        = (state == IDLE) || done;
    win        = (req0 && req1) ? ptr : req1;
    pick       = win ? txn_t'{1'b1, we1, addr1, wdata1} : txn_t'{1'b0, we0, addr0, wdata0};
    case (state)
      ISSUE: begin
        if (cur.we) state_nxt = IDLE;
        else begin
          state_nxt = WAIT;
          cnt_nxt   = 3'd1;
          cen_nxt   = 1'b0;
        end
      end
      WAIT: begin
        cen_nxt = 1'b0;
        cnt_nxt = cnt + 3'd1;
        if (done) begin
          rdata_nxt            = mem_dout;
          rvalid_nxt[cur.port] = 1'b1;
          state_nxt            = IDLE;
          cen_nxt              = 1'b1;
          cnt_nxt              = '0;
        end
      end
      default: ;
    endcase
    if (arb && (req0 || req1)) begin
      state_nxt    = ISSUE;
      cur_nxt      = pick;
      ptr_nxt      = ~win;
      gnt_nxt[win] = 1'b1;
      cen_nxt      = 1'b0;
      add_nxt      = pick.addr;
      wr_nxt       = pick.we;
      rd_nxt       = ~pick.we;
      din_nxt      = pick.we ? pick.wdata : '0;
    end
    busy_nxt = (state_nxt != IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      cur      <= '0;
      ptr      <= 1'b0;
      cnt      <= '0;
      gnt_q    <= '0;
      rvalid_q <= '0;
      rdata    <= '0;
      busy     <= 1'b0;
      mem_cen  <= 1'b1;
      mem_rd   <= 1'b0;
      mem_wr   <= 1'b0;
      mem_add  <= '0;
      mem_din  <= '0;
    end else begin
      state    <= state_nxt;
      cur      <= cur_nxt;
      ptr      <= ptr_nxt;
      cnt      <= cnt_nxt;
      gnt_q    <= gnt_nxt;
      rvalid_q <= rvalid_nxt;
      rdata    <= rdata_nxt;
      busy     <= busy_nxt;
      mem_cen  <= cen_nxt;
      mem_rd   <= rd_nxt;
      mem_wr   <= wr_nxt;
      mem_add  <= add_nxt;
      mem_din  <= din_nxt;
    end
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: behavioural memory, transaction-level arbiter model and
// a negedge monitor that checks every cycle against queued expectations.
module tb_mem_arbiter;
  localparam int AW = 12, DW = 8, RD_LAT = 2;

  typedef struct {logic we; logic [AW-1:0] addr; logic [DW-1:0] wdata;} txn_t;
  typedef struct {int port; logic [DW-1:0] data; int due;} rexp_t;

  logic clk = 1'b0, rst = 1'b0;
  logic [1:0] req = '0, we = '0, gnt, rvalid;
  logic [AW-1:0] addr [2];
  logic [DW-1:0] wdata [2];
  logic [DW-1:0] rdata, mem_din, mem_dout;
  logic busy, mem_cen, mem_rd, mem_wr;
  logic [AW-1:0] mem_add;

  always #5 clk = ~clk;

  mem_arbiter #(.AW(AW), .DW(DW), .RD_LAT(RD_LAT)) dut (
    .clk(clk), .rst(rst),
    .req0(req[0]), .req1(req[1]), .we0(we[0]), .we1(we[1]),
    .addr0(addr[0]), .addr1(addr[1]), .wdata0(wdata[0]), .wdata1(wdata[1]),
    .gnt0(gnt[0]), .gnt1(gnt[1]), .rvalid0(rvalid[0]), .rvalid1(rvalid[1]),
    .rdata(rdata), .busy(busy), .mem_cen(mem_cen), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .mem_add(mem_add), .mem_din(mem_din), .mem_dout(mem_dout)
  );

  int errs = 0, checks = 0, cyc = 0;
  txn_t pq [2][$];
  rexp_t rd_exp [$];
  int glog [$];
  int n_rv = 0, n_rdgnt = 0;
  logic [DW-1:0] ref_mem [0:(1<<AW)-1];
  logic [DW-1:0] mem_arr [0:(1<<AW)-1];
  logic [DW-1:0] rpipe [RD_LAT];
  logic rst_e = 1'b0;
  logic [1:0] req_e = '0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // memory with fixed read latency; non-read slots carry garbage
  always @(posedge clk) begin
    if (!mem_cen && mem_wr) mem_arr[mem_add] = mem_din;
    rpipe[0] <= (!mem_cen && mem_rd) ? mem_arr[mem_add] : DW'($urandom);
    for (int i = 1; i < RD_LAT; i++) rpipe[i] <= rpipe[i-1];
  end
  assign mem_dout = rpipe[RD_LAT-1];

  always @(posedge clk) begin
    rst_e <= rst;
    req_e <= req;
  end

  initial begin : monitor
    logic [1:0] gexp;
    int win, free_edge, wait_lo, wait_hi;
    bit ptr;
    logic [AW-1:0] wait_addr;
    logic [DW-1:0] last_rd;
    txn_t t;
    rexp_t e;
    free_edge = 0; wait_lo = 1; wait_hi = 0; ptr = 1'b0; last_rd = '0; wait_addr = '0;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst || !rst_e) begin
        chk("rst_gnt", 32'(gnt), 0);
        chk("rst_rvalid", 32'(rvalid), 0);
        chk("rst_cen", 32'(mem_cen), 1);
        chk("rst_strobes", 32'({mem_rd, mem_wr}), 0);
        chk("rst_rdata", 32'(rdata), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_add_din", 32'({mem_add, mem_din}), 0);
        ptr = 1'b0; free_edge = 0; wait_lo = 1; wait_hi = 0;
        rd_exp.delete(); last_rd = '0; n_rv = 0; n_rdgnt = 0;
      end else begin
        gexp = 2'b00; win = 0;
        if (cyc >= free_edge && req_e != 2'b00) begin
          win = (req_e == 2'b11) ? int'(ptr) : (req_e[1] ? 1 : 0);
          gexp[win] = 1'b1;
        end
        chk("gnt", 32'(gnt), 32'(gexp));
        chk("busy", 32'(busy), 32'(gexp != 2'b00 || (cyc >= wait_lo && cyc <= wait_hi)));
        chk("rd_and_wr", 32'(mem_rd & mem_wr), 0);
        if (gexp != 2'b00) begin
          ptr = (win == 0);
          glog.push_back(win);
          if (pq[win].size() == 0) begin
            errs++; checks++;
            $display("FAIL grant_without_req: port %0d granted, required no grant (cycle %0d)", win, cyc);
          end else begin
            t = pq[win].pop_front();
            chk("cmd_cen", 32'(mem_cen), 0);
            chk("cmd_wr", 32'(mem_wr), 32'(t.we));
            chk("cmd_rd", 32'(mem_rd), 32'(!t.we));
            chk("cmd_add", 32'(mem_add), 32'(t.addr));
            chk("cmd_din", 32'(mem_din), t.we ? 32'(t.wdata) : 0);
            if (t.we) begin
              ref_mem[t.addr] = t.wdata;
              free_edge = cyc + 2;
            end else begin
              rd_exp.push_back(rexp_t'{win, ref_mem[t.addr], cyc + 1 + RD_LAT});
              free_edge = cyc + 1 + RD_LAT;
              wait_lo = cyc + 1; wait_hi = cyc + RD_LAT; wait_addr = t.addr;
              n_rdgnt++;
            end
          end
        end else if (cyc >= wait_lo && cyc <= wait_hi) begin
          chk("wait_pins", 32'({mem_cen, mem_rd, mem_wr}), 0);
          chk("wait_add", 32'(mem_add), 32'(wait_addr));
        end else begin
          chk("idle_pins", 32'({mem_cen, mem_rd, mem_wr}), 32'(3'b100));
        end
        if (rd_exp.size() != 0 && rd_exp[0].due == cyc) begin
          e = rd_exp.pop_front();
          chk("rvalid_owner", 32'(rvalid), 32'(1 << e.port));
          last_rd = e.data;
          n_rv++;
        end else begin
          chk("rvalid_idle", 32'(rvalid), 0);
        end
        chk("rdata", 32'(rdata), 32'(last_rd));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic issue(input int p, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    pq[p].push_back(txn_t'{w, a, d});
    we[p] = w; addr[p] = a; wdata[p] = d; req[p] = 1'b1;
  endtask

  task automatic wait_gnt(input int p, output int n);
    bit got;
    txn_t tmp;
    got = 1'b0; n = 0;
    while (!got && n < 200) begin
      tick(); n++;
      got = gnt[p];
    end
    if (!got) begin
      errs++; checks++;
      $display("FAIL gnt_timeout: port %0d saw no gnt in %0d cycles, required a gnt", p, n);
      tmp = pq[p].pop_back();
    end
    req[p] = 1'b0;
  endtask

  task automatic wait_rv(input int p, output int n);
    n = 0;
    while (!rvalid[p] && n < 50) begin
      tick(); n++;
    end
  endtask

  function automatic logic [AW-1:0] rand_addr();
    logic [9:0] w;
    w = 10'($urandom_range(0, 7));
    if ($urandom_range(0, 1) == 1) w = w ^ 10'h3FF;
    return {2'($urandom_range(0, 3)), w};
  endfunction

  task automatic rand_port(input int p);
    int n;
    txn_t tmp;
    for (int k = 0; k < 40; k++) begin
      repeat ($urandom_range(0, 3)) tick();
      issue(p, 1'($urandom_range(0, 1)), rand_addr(), DW'($urandom));
      if ($urandom_range(0, 7) == 0) begin
        tick();
        if (!gnt[p]) tmp = pq[p].pop_back();
        req[p] = 1'b0;
      end else begin
        wait_gnt(p, n);
      end
    end
  endtask

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int n, n1;
    logic [DW-1:0] v;
    for (int i = 0; i < (1 << AW); i++) begin
      v = DW'($urandom);
      mem_arr[i] = v; ref_mem[i] = v;
    end
    addr[0] = '0; addr[1] = '0; wdata[0] = '0; wdata[1] = '0;

    // reset held with random inputs; requests are not queued because none may be granted
    repeat (5) begin
      tick();
      req = 2'($urandom); we = 2'($urandom);
      addr[0] = AW'($urandom); addr[1] = AW'($urandom);
      wdata[0] = DW'($urandom); wdata[1] = DW'($urandom);
    end
    tick();
    req = '0;
    issue(0, 1'b1, 12'hC05, 8'hA5);
    rst = 1'b1;
    wait_gnt(0, n);
    chk("first_req_after_reset_edges", 32'(n), 1);

    tick();
    issue(0, 1'b0, 12'hC05, 8'h00);
    wait_gnt(0, n);
    wait_rv(0, n1);
    chk("read_rvalid_latency", 32'(n + n1 - 1), 32'(RD_LAT + 1));
    chk("read_rdata_A5", 32'(rdata), 32'h0A5);

    // contention: both ports held for four transactions
    repeat (4) tick();
    glog.delete();
    issue(0, 1'b1, 12'h100, 8'h11);
    issue(1, 1'b1, 12'h3FF, 8'h5A);
    fork wait_gnt(0, n); wait_gnt(1, n1); join
    issue(0, 1'b0, 12'h100, 8'h00);
    issue(1, 1'b0, 12'h3FF, 8'h00);
    fork wait_gnt(0, n); wait_gnt(1, n1); join
    repeat (RD_LAT + 4) tick();
    chk("contention_grants", 32'(glog.size()), 4);
    if (glog.size() == 4)
      chk("contention_order", 32'({glog[0][1:0], glog[1][1:0], glog[2][1:0], glog[3][1:0]}), 32'(8'b01_00_01_00));

    // back-to-back: second read sampled on the capture edge of the first
    issue(1, 1'b0, 12'h3FF, 8'h00);
    wait_gnt(1, n);
    issue(1, 1'b0, 12'h400, 8'h00);
    wait_gnt(1, n);
    chk("b2b_gnt_edges", 32'(n), 32'(RD_LAT + 1));
    chk("b2b_rvalid_with_gnt", 32'({gnt[1], rvalid[1]}), 32'(2'b11));
    repeat (RD_LAT + 4) tick();

    // reset during WAIT
    issue(0, 1'b0, 12'h123, 8'h00);
    wait_gnt(0, n);
    tick();
    rst = 1'b0;
    #1;
    chk("async_rst_cen", 32'({mem_cen, mem_rd, busy}), 32'(3'b100));
    repeat (3) tick();
    rst = 1'b1;
    glog.delete();
    issue(0, 1'b1, 12'h7FE, 8'h3C);
    issue(1, 1'b1, 12'h801, 8'hC3);
    fork wait_gnt(0, n); wait_gnt(1, n1); join
    chk("ptr_after_reset", 32'(glog.size() > 0 ? glog[0] : -1), 0);
    repeat (RD_LAT + 4) tick();

    // random traffic on both ports
    fork rand_port(0); rand_port(1); join
    repeat (RD_LAT + 6) tick();
    chk("pending_port0", 32'(pq[0].size()), 0);
    chk("pending_port1", 32'(pq[1].size()), 0);
    chk("reads_outstanding", 32'(rd_exp.size()), 0);
    chk("rvalid_count", 32'(n_rv), 32'(n_rdgnt));

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
